// File: rtl/orientation_histogram_if.sv
// Sample input and bin-total output ports of the orientation histogram.
`timescale 1ns/1ps
interface orientation_histogram_if #(
  parameter int unsigned MAG_BITS = 16,
  parameter int unsigned ACC_BITS = 24
);
  logic                in_valid;
  logic                in_ready;
  logic [5:0]          in_sector;
  logic                in_nan;
  logic [MAG_BITS-1:0] in_mag;
  logic                out_valid;
  logic                out_ready;
  logic [5:0]          out_bin;
  logic [ACC_BITS-1:0] out_count;
  logic                out_last;

  modport master (
    output in_valid, in_sector, in_nan, in_mag, out_ready,
    input  in_ready, out_valid, out_bin, out_count, out_last
  );

  modport slave (
    input  in_valid, in_sector, in_nan, in_mag, out_ready,
    output in_ready, out_valid, out_bin, out_count, out_last
  );
endinterface

// File: rtl/orientation_histogram.sv
// 64-bin orientation histogram: accumulates saturating magnitudes per sector,
// then streams and clears all bins once a cell of samples has been accepted.
`timescale 1ns/1ps
module orientation_histogram #(
  parameter int unsigned MAG_BITS     = 16,
  parameter int unsigned ACC_BITS     = 24,
  parameter int unsigned CELL_SAMPLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  orientation_histogram_if.slave bus
);
  localparam int unsigned NUM_BINS = 64;
  localparam int unsigned BIN_BITS = 6;
  localparam int unsigned SUM_BITS = ACC_BITS + 1;
  localparam int unsigned CNT_BITS = $clog2(CELL_SAMPLES + 1);

  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_DUMP} state_e;

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [BIN_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [BIN_BITS-1:0]   s1_sector_q;
  logic [MAG_BITS-1:0]   s1_mag_q;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [BIN_BITS-1:0]   out_bin_q, out_bin_d;
  logic [ACC_BITS-1:0]   out_count_q, out_count_d;
  logic                  out_last_q, out_last_d;
  logic [ACC_BITS-1:0]   bins_q [NUM_BINS];

  logic                  accept_c, xfer_c, clr_we_c;
  logic [BIN_BITS-1:0]   nxt_bin_c;
  logic [SUM_BITS-1:0]   sum_c;
  logic [ACC_BITS-1:0]   acc_new_c;

  assign accept_c  = bus.in_valid && in_ready_q;
  assign xfer_c    = out_valid_q && bus.out_ready;
  assign nxt_bin_c = out_bin_q + BIN_BITS'(1);

  // Single-stage read-modify-write: the write lands before the next read, so
  // back-to-back hits on one bin see each other's result without a stall.
  assign sum_c     = SUM_BITS'(bins_q[s1_sector_q]) + SUM_BITS'(s1_mag_q);
  assign acc_new_c = sum_c[ACC_BITS] ? '1 : sum_c[ACC_BITS-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_idx_d   = clr_idx_q;
    s1_valid_d  = accept_c && !bus.in_nan;
    in_ready_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    clr_we_c    = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we_c  = 1'b1;
        clr_idx_d = clr_idx_q + BIN_BITS'(1);
        if (clr_idx_q == BIN_BITS'(NUM_BINS - 1)) begin
          state_d    = S_ACCUM;
          in_ready_d = 1'b1;
        end
      end
      S_ACCUM: begin
        in_ready_d = 1'b1;
        if (accept_c) begin
          cnt_d = cnt_q + CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(CELL_SAMPLES - 1)) begin
            state_d    = S_DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q) begin
          state_d     = S_DUMP;
          out_valid_d = 1'b1;
          out_bin_d   = '0;
          out_count_d = bins_q[0];
          out_last_d  = 1'b0;
        end
      end
      S_DUMP: begin
        if (xfer_c) begin
          if (out_last_q) begin
            state_d     = S_ACCUM;
            in_ready_d  = 1'b1;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_bin_d   = '0;
            out_last_d  = 1'b0;
          end else begin
            out_bin_d   = nxt_bin_c;
            out_count_d = bins_q[nxt_bin_c];
            out_last_d  = (nxt_bin_c == BIN_BITS'(NUM_BINS - 1));
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      clr_idx_q   <= '0;
      s1_valid_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_idx_q   <= clr_idx_d;
      s1_valid_q  <= s1_valid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      s1_sector_q <= bus.in_sector;
      s1_mag_q    <= bus.in_mag;
    end
  end

  // Bin storage: clear sweep, read-to-clear on transfer, accumulate write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we_c) begin
        bins_q[clr_idx_q] <= '0;
      end else if (xfer_c) begin
        bins_q[out_bin_q] <= '0;
      end else if (s1_valid_q) begin
        bins_q[s1_sector_q] <= acc_new_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_orientation_histogram.sv
// Bench for orientation_histogram: two instances (24- and 20-bit bins) in lockstep,
// scoreboard of expected dumps, table of cells plus reset corner sequences.
`timescale 1ns/1ps
module tb_orientation_histogram;
  localparam int unsigned MAG_BITS = 16;
  localparam int unsigned ACC_A    = 24;
  localparam int unsigned ACC_B    = 20;

  typedef struct {
    logic [5:0]  bin;
    logic [23:0] cnt;
    logic        last;
  } exp_t;

  typedef struct {
    string       name;
    bit          spread;
    logic [5:0]  sector;
    logic [15:0] mag;
    bit          nan;
    bit          bp;
    logic [5:0]  hot;
    logic [23:0] hot_a;
    logic [23:0] hot_b;
  } cell_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  in_sector = '0;
  logic        in_nan = 1'b0;
  logic [15:0] in_mag = '0;
  logic        out_ready = 1'b1;
  bit          bp_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int vcycles = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [23:0] mdl_a [64];
  logic [23:0] mdl_b [64];
  int          mdl_cnt = 0;
  logic [23:0] got_a [64];
  logic [23:0] got_b [64];
  bit          hold_a = 0, hold_b = 0;
  logic [30:0] held_a, held_b;

  orientation_histogram_if #(.MAG_BITS(MAG_BITS), .ACC_BITS(ACC_A)) ifa ();
  orientation_histogram_if #(.MAG_BITS(MAG_BITS), .ACC_BITS(ACC_B)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_sector = in_sector;
  assign ifa.in_nan    = in_nan;
  assign ifa.in_mag    = in_mag;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_sector = in_sector;
  assign ifb.in_nan    = in_nan;
  assign ifb.in_mag    = in_mag;
  assign ifb.out_ready = out_ready;

  orientation_histogram #(.MAG_BITS(MAG_BITS), .ACC_BITS(ACC_A), .CELL_SAMPLES(64)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  orientation_histogram #(.MAG_BITS(MAG_BITS), .ACC_BITS(ACC_B), .CELL_SAMPLES(64)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=completion", nm);
  endfunction

  function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [15:0] m, input int bits);
    longint s;
    longint mx;
    s  = longint'(a) + longint'(m);
    mx = (longint'(1) << bits) - 1;
    if (s > mx) s = mx;
    return s[23:0];
  endfunction

  function automatic void model_accept(input logic [5:0] s, input logic [15:0] m, input bit n);
    exp_t e;
    if (!n) begin
      mdl_a[s] = sat_add(mdl_a[s], m, ACC_A);
      mdl_b[s] = sat_add(mdl_b[s], m, ACC_B);
    end
    mdl_cnt++;
    if (mdl_cnt == 64) begin
      for (int b = 0; b < 64; b++) begin
        e.bin = 6'(b); e.last = (b == 63);
        e.cnt = mdl_a[b]; qa.push_back(e);
        e.cnt = mdl_b[b]; qb.push_back(e);
        mdl_a[b] = '0;
        mdl_b[b] = '0;
      end
      mdl_cnt = 0;
    end
  endfunction

  // Output monitor: compares transfers against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_a = 0;
      hold_b = 0;
    end else begin
      if (ifa.out_valid) begin
        vcycles++;
        if (hold_a) chk("stall_hold_a", 32'({ifa.out_bin, ifa.out_count, ifa.out_last}), 32'(held_a));
        if (out_ready) begin
          hold_a = 0;
          if (qa.size() == 0) begin
            chk("unexpected_out_a", 32'(ifa.out_bin), 32'hFFFF_FFFF);
          end else begin
            e = qa.pop_front();
            chk("dump_bin_a", 32'(ifa.out_bin), 32'(e.bin));
            chk("dump_cnt_a", 32'(ifa.out_count), 32'(e.cnt));
            chk("dump_last_a", 32'(ifa.out_last), 32'(e.last));
            got_a[ifa.out_bin] = ifa.out_count;
          end
        end else begin
          hold_a = 1;
          held_a = {ifa.out_bin, ifa.out_count, ifa.out_last};
        end
      end
      if (ifb.out_valid) begin
        if (hold_b) chk("stall_hold_b", 32'({ifb.out_bin, ifb.out_count, ifb.out_last}), 32'(held_b));
        if (out_ready) begin
          hold_b = 0;
          if (qb.size() == 0) begin
            chk("unexpected_out_b", 32'(ifb.out_bin), 32'hFFFF_FFFF);
          end else begin
            e = qb.pop_front();
            chk("dump_bin_b", 32'(ifb.out_bin), 32'(e.bin));
            chk("dump_cnt_b", 32'(ifb.out_count), 32'(e.cnt));
            chk("dump_last_b", 32'(ifb.out_last), 32'(e.last));
            got_b[ifb.out_bin] = 24'(ifb.out_count);
          end
        end else begin
          hold_b = 1;
          held_b = 31'({ifb.out_bin, ifb.out_count, ifb.out_last});
        end
      end
    end
  end

  task automatic send(input logic [5:0] s, input logic [15:0] m, input bit n);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    in_valid = 1'b1; in_sector = s; in_mag = m; in_nan = n;
    while (!acc && guard < 400) begin
      @(negedge clk);
      acc = ifa.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) fail_now("accept_timeout");
    else model_accept(s, m, n);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 5000) fail_now("drain_timeout");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  cell_t cells [6];

  initial begin
    int bad;
    int g;
    cells[0] = '{"nan_cell",  1'b0, 6'd0,  16'd0,     1'b1, 1'b0, 6'd0,  24'd0,       24'd0};
    cells[1] = '{"spread",    1'b1, 6'd0,  16'd0,     1'b0, 1'b0, 6'd63, 24'd64,      24'd64};
    cells[2] = '{"same_bin",  1'b0, 6'd17, 16'd1000,  1'b0, 1'b0, 6'd17, 24'd64000,   24'd64000};
    cells[3] = '{"saturate",  1'b0, 6'd5,  16'd65535, 1'b0, 1'b0, 6'd5,  24'd4194240, 24'd1048575};
    cells[4] = '{"backpress", 1'b1, 6'd0,  16'd0,     1'b0, 1'b1, 6'd40, 24'd41,      24'd41};
    cells[5] = '{"after_bp",  1'b0, 6'd9,  16'd3,     1'b0, 1'b0, 6'd9,  24'd192,     24'd192};
    for (int b = 0; b < 64; b++) begin
      mdl_a[b] = '0; mdl_b[b] = '0; got_a[b] = '1; got_b[b] = '1;
    end

    // Reset with a sample held on the input; CLEAR must ignore it for 64 cycles.
    reset = 1'b1; in_valid = 1'b1; in_nan = 1'b1; in_mag = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_bin", 32'(ifa.out_bin), 32'd0);
    chk("rst_out_count", 32'(ifa.out_count), 32'd0);
    chk("rst_out_last", 32'(ifa.out_last), 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ifa.in_ready !== 1'b0 || ifb.in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    chk("clear_ready_low_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    chk("clear_ready_high", 32'(ifa.in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int c = 0; c < 6; c++) begin
      vcycles = 0;
      bp_en = cells[c].bp;
      for (int i = 0; i < 64; i++) begin
        send(cells[c].spread ? 6'(i) : cells[c].sector,
             cells[c].spread ? 16'(i + 1) : cells[c].mag, cells[c].nan);
      end
      wait_drain();
      bp_en = 1'b0;
      if (!cells[c].bp) chk({cells[c].name, "_valid_cycles"}, 32'(vcycles), 32'd64);
      chk({cells[c].name, "_hot_a"}, 32'(got_a[cells[c].hot]), 32'(cells[c].hot_a));
      chk({cells[c].name, "_hot_b"}, 32'(got_b[cells[c].hot]), 32'(cells[c].hot_b));
    end

    // Reset right after bin 20 transfers; partial dump is discarded.
    for (int i = 0; i < 64; i++) send(6'd10, 16'd7, 1'b0);
    g = 0;
    while (qa.size() > 43 && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 3000) fail_now("mid_dump_wait");
    chk("mid_dump_bin10_a", 32'(got_a[10]), 32'd448);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("mid_rst_out_bin", 32'(ifa.out_bin), 32'd0);
    chk("mid_rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("mid_rst_out_valid_b", 32'(ifb.out_valid), 32'd0);
    qa.delete();
    qb.delete();
    reset = 1'b0;
    for (int b = 0; b < 64; b++) begin
      got_a[b] = '1; got_b[b] = '1;
    end
    vcycles = 0;
    for (int i = 0; i < 64; i++) send(6'd40, 16'd2, 1'b0);
    wait_drain();
    chk("post_rst_bin40_a", 32'(got_a[40]), 32'd128);
    chk("post_rst_bin40_b", 32'(got_b[40]), 32'd128);
    chk("post_rst_bin10_a", 32'(got_a[10]), 32'd0);
    chk("post_rst_valid_cycles", 32'(vcycles), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
